// File: rtl/memset_beat_sequencer_pkg.sv
// Shared widths, FSM encoding, beat payload and last-beat strobe helper
// for the memset beat sequencer.
package memset_pkg;

    localparam int unsigned DataWidth    = 512;
    localparam int unsigned LenWidth     = 32;
    localparam int unsigned BytesPerBeat = DataWidth / 8;
    localparam int unsigned OffWidth     = $clog2(BytesPerBeat);
    localparam int unsigned CntWidth     = LenWidth + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } memset_seq_state_e;

    typedef struct packed {
        logic [DataWidth-1:0]    bits;
        logic [BytesPerBeat-1:0] strb;
        logic                    last;
    } beat_t;

    // Byte mask of the final beat; a zero remainder means a full beat.
    function automatic logic [BytesPerBeat-1:0] tail_strb(input logic [OffWidth-1:0] len_rem);
        if (len_rem == '0) begin
            return '1;
        end
        return (BytesPerBeat'(1) << len_rem) - BytesPerBeat'(1);
    endfunction

endpackage

// File: rtl/memset_beat_sequencer_if.sv
// Ready/valid beat stream from the sequencer toward the memset accelerator.
interface memset_beat_sequencer_if;
    import memset_pkg::*;

    logic                    ready;
    logic                    valid;
    logic [DataWidth-1:0]    bits;
    logic [BytesPerBeat-1:0] strb;
    logic                    last;

    modport master (input ready, output valid, bits, strb, last);
    modport slave  (output ready, input valid, bits, strb, last);

endinterface

// File: rtl/memset_beat_sequencer.sv
// Converts a byte-length CSR plus start pulse into an exact run of strobed
// beats, and reports busy/done to the CSR manager.
module memset_beat_sequencer
    import memset_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LenWidth-1:0]      ext_csr_i_0,
    input  logic                     ext_start_i,
    output logic                     ext_busy_o,
    output logic                     ext_done_o,
    memset_beat_sequencer_if.master  ext_data_o
);

    memset_seq_state_e       state_q;
    logic [CntWidth-1:0]     beats_left_q;
    logic [LenWidth-1:0]     idx_q;
    logic [BytesPerBeat-1:0] tail_q;
    beat_t                   beat_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    fire_c;
    logic [CntWidth-1:0]     nbeats_c;
    logic [CntWidth-1:0]     left_next_c;
    logic [LenWidth-1:0]     idx_next_c;
    logic [BytesPerBeat-1:0] start_tail_c;

    // One extra bit keeps ceil(len/BPB) exact for the all-ones length.
    assign nbeats_c     = (CntWidth'(ext_csr_i_0) + CntWidth'(BytesPerBeat - 1)) >> OffWidth;
    assign start_tail_c = tail_strb(ext_csr_i_0[OffWidth-1:0]);
    assign fire_c       = valid_q & ext_data_o.ready;
    assign left_next_c  = beats_left_q - CntWidth'(1);
    assign idx_next_c   = idx_q + LenWidth'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            idx_q        <= '0;
            tail_q       <= '0;
            beat_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ext_start_i) begin
                        busy_q <= 1'b1;
                        if (ext_csr_i_0 == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= RUN;
                            beats_left_q <= nbeats_c;
                            idx_q        <= '0;
                            tail_q       <= start_tail_c;
                            valid_q      <= 1'b1;
                            beat_q.bits  <= '0;
                            beat_q.last  <= (nbeats_c == CntWidth'(1));
                            beat_q.strb  <= (nbeats_c == CntWidth'(1)) ? start_tail_c : '1;
                        end
                    end
                end
                RUN: begin
                    // Next beat is loaded on the firing edge so the stream has no bubbles.
                    if (fire_c) begin
                        if (beat_q.last) begin
                            valid_q <= 1'b0;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q        <= idx_next_c;
                            beats_left_q <= left_next_c;
                            beat_q.bits  <= DataWidth'(idx_next_c);
                            beat_q.last  <= (left_next_c == CntWidth'(1));
                            beat_q.strb  <= (left_next_c == CntWidth'(1)) ? tail_q : '1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ext_busy_o       = busy_q;
    assign ext_done_o       = done_q;
    assign ext_data_o.valid = valid_q;
    assign ext_data_o.bits  = beat_q.bits;
    assign ext_data_o.strb  = beat_q.strb;
    assign ext_data_o.last  = beat_q.last;

endmodule

// File: tb/tb_memset_beat_sequencer.sv
// Bench for memset_beat_sequencer: job-level model checked every cycle plus directed scenarios.
module tb_memset_beat_sequencer;
    import memset_pkg::*;

    localparam int unsigned Bpb = DataWidth / 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [LenWidth-1:0] csr = '0;
    logic                start = 1'b0;
    logic                busy;
    logic                done;

    memset_beat_sequencer_if ext_data_o ();

    memset_beat_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .ext_csr_i_0 (csr),
        .ext_start_i (start),
        .ext_busy_o  (busy),
        .ext_done_o  (done),
        .ext_data_o  (ext_data_o)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    longint fires    = 0;
    longint job_q[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint exp_nbeats(input longint len);
        return (len + longint'(Bpb) - 1) / longint'(Bpb);
    endfunction

    function automatic logic [Bpb-1:0] exp_strb(input longint len, input longint idx, input longint n);
        logic [Bpb-1:0] s;
        longint rem;
        s = '1;
        if (idx == n - 1) begin
            rem = len % longint'(Bpb);
            if (rem != 0) begin
                s = '0;
                for (int b = 0; b < int'(rem); b++) s[b] = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Job-level model: beat k of a job of len bytes carries index k, full strobe
    // except on the final beat, and last only on beat n-1.
    initial begin : compare
        bit     active;
        longint cur_len, cur_n, cur_idx;
        active = 0;
        cur_len = 0; cur_n = 0; cur_idx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                job_q.delete();
            end else if (ext_data_o.valid) begin
                if (!active && job_q.size() > 0) begin
                    cur_len = job_q.pop_front();
                    cur_n   = exp_nbeats(cur_len);
                    cur_idx = 0;
                    active  = 1;
                end
                check("beat_expected", 512'(active), 512'(1));
                if (active) begin
                    check("beat_bits", 512'(ext_data_o.bits), 512'(cur_idx[31:0]));
                    check("beat_strb", 512'(ext_data_o.strb), 512'(exp_strb(cur_len, cur_idx, cur_n)));
                    check("beat_last", 512'(ext_data_o.last), 512'(cur_idx == cur_n - 1));
                    if (ext_data_o.ready) begin
                        fires++;
                        cur_idx++;
                        if (cur_idx == cur_n) active = 0;
                    end
                end
            end
        end
    end

    function automatic logic ready_pat(input int pat, input int cyc);
        case (pat)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one job to completion; optionally pulses start with another length mid-job.
    task automatic run_job(input logic [31:0] len, input int pat, input int glitch_cyc, input int budget);
        longint f0;
        int     cyc;
        f0 = fires;
        cyc = 0;
        ext_data_o.ready = ready_pat(pat, 0);
        csr = len;
        start = 1'b1;
        if (len != 0) job_q.push_back(longint'(len));
        tick();
        start = 1'b0;
        while (!done && cyc < budget) begin
            check("busy_in_job", 512'(busy), 512'(1));
            cyc++;
            ext_data_o.ready = ready_pat(pat, cyc);
            if (cyc == glitch_cyc) begin
                start = 1'b1;
                csr   = 32'd64;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("done_seen", 512'(done), 512'(1));
        check("busy_at_done", 512'(busy), 512'(1));
        check("valid_at_done", 512'(ext_data_o.valid), 512'(0));
        check("fire_count", 512'(fires - f0), 512'(exp_nbeats(longint'(len))));
        tick();
        check("done_one_cycle", 512'(done), 512'(0));
        check("busy_cleared", 512'(busy), 512'(0));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] held;
        ext_data_o.ready = 1'b0;

        // Pin the model against hand-computed values.
        check("model_nbeats_128", 512'(exp_nbeats(128)), 512'(2));
        check("model_nbeats_130", 512'(exp_nbeats(130)), 512'(3));
        check("model_nbeats_max", 512'(exp_nbeats(longint'(32'hFFFF_FFFF))), 512'(67108864));
        check("model_strb_130_b2", 512'(exp_strb(130, 2, 3)), 512'(64'h3));
        check("model_strb_130_b0", 512'(exp_strb(130, 0, 3)), {448'd0, {64{1'b1}}});
        check("model_strb_128_b1", 512'(exp_strb(128, 1, 2)), {448'd0, {64{1'b1}}});

        tick();
        tick();
        check("rst_valid", 512'(ext_data_o.valid), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_bits", 512'(ext_data_o.bits), 512'(0));
        check("rst_strb", 512'(ext_data_o.strb), 512'(0));
        check("rst_last", 512'(ext_data_o.last), 512'(0));
        rst = 1'b0;
        tick();

        // len=128, ready=1: beats at cycles 1,2, done at cycle 3.
        ext_data_o.ready = 1'b1;
        csr = 32'd128;
        start = 1'b1;
        job_q.push_back(128);
        tick();
        start = 1'b0;
        check("l128_c1_valid", 512'(ext_data_o.valid), 512'(1));
        check("l128_c1_busy", 512'(busy), 512'(1));
        check("l128_c1_bits", 512'(ext_data_o.bits), 512'(0));
        check("l128_c1_last", 512'(ext_data_o.last), 512'(0));
        tick();
        check("l128_c2_valid", 512'(ext_data_o.valid), 512'(1));
        check("l128_c2_bits", 512'(ext_data_o.bits), 512'(1));
        check("l128_c2_last", 512'(ext_data_o.last), 512'(1));
        check("l128_c2_strb", 512'(ext_data_o.strb), {448'd0, {64{1'b1}}});
        tick();
        check("l128_c3_done", 512'(done), 512'(1));
        check("l128_c3_busy", 512'(busy), 512'(1));
        check("l128_c3_valid", 512'(ext_data_o.valid), 512'(0));
        tick();
        check("l128_c4_done", 512'(done), 512'(0));
        check("l128_c4_busy", 512'(busy), 512'(0));

        // Back-to-back jobs with assorted lengths and ready patterns.
        run_job(32'd130, 0, -1, 50);
        run_job(32'd0,   0, -1, 50);
        run_job(32'd1,   0, -1, 50);
        run_job(32'd256, 1, -1, 50);
        run_job(32'd200, 1, -1, 50);
        run_job(32'd640, 0, 3,  50);
        check("idle_after_ignore_valid", 512'(ext_data_o.valid), 512'(0));
        tick();
        check("idle_after_ignore_busy", 512'(busy), 512'(0));

        // Maximum length, stalled mid-job, then aborted by reset.
        ext_data_o.ready = 1'b1;
        csr = 32'hFFFF_FFFF;
        start = 1'b1;
        job_q.push_back(longint'(32'hFFFF_FFFF));
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        ext_data_o.ready = 1'b0;
        tick();
        held = ext_data_o.bits[31:0];
        tick();
        check("max_stall_bits", 512'(ext_data_o.bits), 512'(3));
        check("max_stall_held", 512'(ext_data_o.bits[31:0]), 512'(held));
        check("max_stall_last", 512'(ext_data_o.last), 512'(0));
        check("max_stall_strb", 512'(ext_data_o.strb), {448'd0, {64{1'b1}}});
        rst = 1'b1;
        tick();
        check("abort_valid", 512'(ext_data_o.valid), 512'(0));
        check("abort_busy", 512'(busy), 512'(0));
        check("abort_done", 512'(done), 512'(0));
        rst = 1'b0;
        tick();
        run_job(32'd130, 1, -1, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
